step_pulse_gen: RTL

Step pulse generator for the stepper-motor drive path. It consumes the tracking loop's step period `N`, direction request `drv_dir` and motor enable `drv_enable_SM`, and produces the physical STEP/DIR signals for the external driver. Its guarantees are a minimum pulse width, direction setup before any step, and no runt pulses. It also keeps a signed absolute position counter of issued steps.

---
 rtl/step_pulse_if.sv | 24 ++
 rtl/step_pulse_gen.sv | 116 +++++++++++
 2 files changed

// File: rtl/step_pulse_if.sv
// STEP/DIR driver bundle: motion requests in, driver-facing pulses and position out.
interface step_pulse_if #(
    parameter int WIDTH_WORK = 16,
    parameter int POS_WIDTH  = 32
);
    logic [WIDTH_WORK-1:0]       N;
    logic                        drv_dir;
    logic                        drv_enable_SM;
    logic                        zero_pos;
    logic                        step;
    logic                        dir;
    logic                        busy;
    logic signed [POS_WIDTH-1:0] position;

    modport master (
        output N, drv_dir, drv_enable_SM, zero_pos,
        input  step, dir, busy, position
    );

    modport slave (
        input  N, drv_dir, drv_enable_SM, zero_pos,
        output step, dir, busy, position
    );
endinterface

// File: rtl/step_pulse_gen.sv
// Stepper STEP/DIR pulse generator: fixed-width pulses, DIR setup before any
// step, period clamped to N_MIN, and a signed count of issued steps.
module step_pulse_gen #(
    parameter int WIDTH_WORK  = 16,
    parameter int PULSE_WIDTH = 50,
    parameter int DIR_SETUP   = 25,
    parameter int N_MIN       = 100,
    parameter int POS_WIDTH   = 32
) (
    input  logic          clk,
    input  logic          rst,
    step_pulse_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

    localparam logic [WIDTH_WORK-1:0] PW_W   = WIDTH_WORK'(PULSE_WIDTH);
    localparam logic [WIDTH_WORK-1:0] DS_W   = WIDTH_WORK'(DIR_SETUP);
    localparam logic [WIDTH_WORK-1:0] NMIN_W = WIDTH_WORK'(N_MIN);
    localparam logic [WIDTH_WORK-1:0] ONE_W  = WIDTH_WORK'(1);

    state_t                  state, state_next;
    logic [WIDTH_WORK-1:0]   cnt, cnt_next;
    logic [WIDTH_WORK-1:0]   p_lat, p_next;
    logic [WIDTH_WORK-1:0]   p_req;
    logic                    dir_next;
    logic                    start;
    logic                    rise;

    function automatic logic [WIDTH_WORK-1:0] clamp_period(input logic [WIDTH_WORK-1:0] n);
        return (n < NMIN_W) ? NMIN_W : n;
    endfunction

    assign p_req = clamp_period(bus.N);
    assign start = bus.drv_enable_SM && (bus.N != '0);

    // Counters are loaded with (duration - 1) on state entry and run down to zero.
    always_comb begin
        state_next = state;
        cnt_next   = (cnt != '0) ? cnt - ONE_W : cnt;
        p_next     = p_lat;
        dir_next   = bus.dir;
        case (state)
            IDLE: begin
                if (start) begin
                    if (bus.drv_dir == bus.dir) begin
                        state_next = HIGH;
                        p_next     = p_req;
                        cnt_next   = PW_W - ONE_W;
                    end else begin
                        state_next = SETUP;
                        dir_next   = bus.drv_dir;
                        cnt_next   = DS_W - ONE_W;
                    end
                end
            end
            SETUP: begin
                if (!bus.drv_enable_SM) begin
                    state_next = IDLE;
                end else if (cnt == '0) begin
                    state_next = HIGH;
                    p_next     = p_req;
                    cnt_next   = PW_W - ONE_W;
                end
            end
            HIGH: begin
                if (cnt == '0) begin
                    state_next = LOW;
                    cnt_next   = p_lat - PW_W - ONE_W;
                end
            end
            LOW: begin
                // Enable loss aborts the low phase immediately; a pulse is never cut.
                if (!bus.drv_enable_SM || ((cnt == '0) && !start)) begin
                    state_next = IDLE;
                end else if (cnt == '0) begin
                    if (bus.drv_dir != bus.dir) begin
                        state_next = SETUP;
                        dir_next   = bus.drv_dir;
                        cnt_next   = DS_W - ONE_W;
                    end else begin
                        state_next = HIGH;
                        p_next     = p_req;
                        cnt_next   = PW_W - ONE_W;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign rise = (state_next == HIGH) && (state != HIGH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            p_lat        <= '0;
            bus.step     <= 1'b0;
            bus.dir      <= 1'b0;
            bus.busy     <= 1'b0;
            bus.position <= '0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            p_lat    <= p_next;
            bus.step <= (state_next == HIGH);
            bus.dir  <= dir_next;
            bus.busy <= (state_next != IDLE);
            if (bus.zero_pos)
                bus.position <= '0;
            else if (rise)
                bus.position <= bus.dir ? bus.position + POS_WIDTH'(1)
                                        : bus.position - POS_WIDTH'(1);
        end
    end
endmodule
